// File: rtl/regfile_pkg.sv
// Shared types, default sizes and the write-port priority helper for the
// multi-port register file.
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 5;

  // Upper bound on write ports that the priority helper can arbitrate.
  localparam int MAX_PORTS = 32;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] reg_data_t;
  typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [MAX_PORTS-1:0]          port_mask_t;

  // Index of the highest set bit in match (the winning write port), or -1
  // when no port matches.
  function automatic int priority_hit(input port_mask_t match);
    int idx;
    idx = -1;
    for (int p = 0; p < MAX_PORTS; p++) begin
      if (match[p]) idx = p;
    end
    return idx;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by a reservation from
// decode and cleared when writeback delivers the result.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 reserve_enable,
  input  logic [ADDR_WIDTH-1:0]                reserve_address,
  input  logic [NUM_WRITE-1:0]                 clear_enable,
  input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] clear_address,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  lookup_address,
  output logic [NUM_READ-1:0]                  busy_bit
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0] busy_q;

  // Clears land first so a same-edge reservation of the same register wins:
  // the newly issued producer supersedes the one being retired.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (clear_enable[w]) busy_q[clear_address[w]] <= 1'b0;
      end
      if (reserve_enable && !(ZERO_REG != 0 && reserve_address == '0)) begin
        busy_q[reserve_address] <= 1'b1;
      end
    end
  end

  // Per-read-port lookup of the stored busy bit.
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      busy_bit[i] = busy_q[lookup_address[i]];
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multi-port register file with hardwired zero register,
// same-cycle write-to-read bypass, busy scoreboard and collision flag.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_WRITE-1:0]                 write_enable,
  input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] write_address,
  input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] data_input,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  read_address,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  data_output,
  output logic [NUM_READ-1:0]                  busy,
  input  logic                                 reserve_enable,
  input  logic [ADDR_WIDTH-1:0]                reserve_address,
  output logic                                 write_conflict
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [NUM_WRITE-1:0]  wr_live;
  logic [NUM_READ-1:0]   busy_bit;
  logic                  conflict_next;
  port_mask_t            earlier_match [NUM_WRITE];
  port_mask_t            read_match    [NUM_READ];

  // A write is live when enabled and not aimed at the hardwired zero register;
  // dropped writes neither store, bypass, clear busy nor count as collisions.
  always_comb begin
    for (int w = 0; w < NUM_WRITE; w++) begin
      wr_live[w] = write_enable[w] && !(ZERO_REG != 0 && write_address[w] == '0);
    end
  end

  // Storage array: later ports are applied last, so the highest index wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < DEPTH; d++) mem[d] <= '0;
    end else begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wr_live[w]) mem[write_address[w]] <= data_input[w];
      end
    end
  end

  // A collision exists when any live port shares its target with a lower port.
  always_comb begin
    conflict_next = 1'b0;
    for (int w = 0; w < NUM_WRITE; w++) begin
      earlier_match[w] = '0;
      for (int v = 0; v < w; v++) begin
        earlier_match[w][v] = wr_live[v] && wr_live[w] &&
                              (write_address[v] == write_address[w]);
      end
      if (priority_hit(earlier_match[w]) >= 0) conflict_next = 1'b1;
    end
  end

  // Collision flag is held for exactly the cycle after the colliding edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) write_conflict <= 1'b0;
    else       write_conflict <= conflict_next;
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_READ   (NUM_READ),
    .NUM_WRITE  (NUM_WRITE),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk             (clk),
    .reset           (reset),
    .reserve_enable  (reserve_enable),
    .reserve_address (reserve_address),
    .clear_enable    (wr_live),
    .clear_address   (write_address),
    .lookup_address  (read_address),
    .busy_bit        (busy_bit)
  );

  // Read muxes: array value, overridden by the winning same-cycle write when
  // bypassing; a bypassed read is no longer waiting on its producer unless
  // a new producer claims the register in this same cycle. Reset forces 0.
  always_comb begin
    int                    hit;
    logic [DATA_WIDTH-1:0] rd;
    logic                  bsy;
    hit = -1;
    rd  = '0;
    bsy = 1'b0;
    for (int i = 0; i < NUM_READ; i++) begin
      read_match[i] = '0;
      for (int w = 0; w < NUM_WRITE; w++) begin
        read_match[i][w] = (BYPASS != 0) && wr_live[w] &&
                           (write_address[w] == read_address[i]);
      end
      hit = priority_hit(read_match[i]);
      rd  = (ZERO_REG != 0 && read_address[i] == '0) ? '0 : mem[read_address[i]];
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (w == hit) rd = data_input[w];
      end
      bsy = busy_bit[i];
      if (hit >= 0 && !(reserve_enable && reserve_address == read_address[i])) bsy = 1'b0;
      if (reset) begin
        rd  = '0;
        bsy = 1'b0;
      end
      data_output[i] = rd;
      busy[i]        = bsy;
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: a bypassing instance, a
// non-bypassing instance on the same stimulus, and a wide/deep sweep instance.
module tb_regfile_multiport;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [1:0]       we;
  logic [1:0][4:0]  wa;
  logic [1:0][31:0] wd;
  logic [1:0][4:0]  ra;
  logic             re;
  logic [4:0]       rsa;

  logic [1:0][31:0] a_do, b_do;
  logic [1:0]       a_busy, b_busy;
  logic             a_wc, b_wc;

  logic [0:0]       c_we;
  logic [0:0][3:0]  c_wa;
  logic [0:0][63:0] c_wd;
  logic [2:0][3:0]  c_ra;
  logic [2:0][63:0] c_do;
  logic [2:0]       c_busy;
  logic             c_wc;
  logic             c_re = 1'b0;
  logic [3:0]       c_rsa = 4'd0;

  regfile_multiport #(.BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .write_enable(we), .write_address(wa),
    .data_input(wd), .read_address(ra), .data_output(a_do), .busy(a_busy),
    .reserve_enable(re), .reserve_address(rsa), .write_conflict(a_wc));

  regfile_multiport #(.BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .write_enable(we), .write_address(wa),
    .data_input(wd), .read_address(ra), .data_output(b_do), .busy(b_busy),
    .reserve_enable(re), .reserve_address(rsa), .write_conflict(b_wc));

  regfile_multiport #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .NUM_READ(3), .NUM_WRITE(1)) dut_c (
    .clk(clk), .reset(reset), .write_enable(c_we), .write_address(c_wa),
    .data_input(c_wd), .read_address(c_ra), .data_output(c_do), .busy(c_busy),
    .reserve_enable(c_re), .reserve_address(c_rsa), .write_conflict(c_wc));

  typedef struct {
    logic [1:0][31:0] a_data;
    logic [1:0]       a_busy;
    logic [1:0][31:0] b_data;
    logic [1:0]       b_busy;
    logic             conflict;
    logic [2:0][63:0] c_data;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state: architectural register contents, pending-producer
  // flags and whether the last edge saw a collision.
  logic [31:0] m_mem  [32];
  logic        m_busy [32];
  logic        m_conf;
  logic [63:0] c_mem  [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the inputs now applied, then advance the model
  // across the coming edge and wait until just after it.
  task automatic step();
    exp_t        e;
    logic [31:0] bv;
    logic        byp;
    logic        nconf;
    for (int i = 0; i < 2; i++) begin
      byp = 1'b0;
      bv  = '0;
      for (int w = 0; w < 2; w++) begin
        if (we[w] && wa[w] == ra[i] && ra[i] != 0) begin
          byp = 1'b1;
          bv  = wd[w];
        end
      end
      e.b_data[i] = (ra[i] == 0) ? 32'd0 : m_mem[ra[i]];
      e.a_data[i] = byp ? bv : e.b_data[i];
      e.b_busy[i] = m_busy[ra[i]];
      e.a_busy[i] = (byp && !(re && rsa == ra[i])) ? 1'b0 : m_busy[ra[i]];
      if (reset) begin
        e.a_data[i] = '0; e.b_data[i] = '0; e.a_busy[i] = 1'b0; e.b_busy[i] = 1'b0;
      end
    end
    e.conflict = reset ? 1'b0 : m_conf;
    for (int i = 0; i < 3; i++) begin
      if (reset || c_ra[i] == 0) e.c_data[i] = '0;
      else if (c_we[0] && c_wa[0] == c_ra[i]) e.c_data[i] = c_wd[0];
      else e.c_data[i] = c_mem[c_ra[i]];
    end
    q.push_back(e);

    if (reset) begin
      for (int r = 0; r < 32; r++) begin m_mem[r] = '0; m_busy[r] = 1'b0; end
      for (int r = 0; r < 16; r++) c_mem[r] = '0;
      m_conf = 1'b0;
    end else begin
      nconf = we[0] && we[1] && wa[0] == wa[1] && wa[0] != 0;
      for (int w = 0; w < 2; w++) begin
        if (we[w] && wa[w] != 0) begin
          m_mem[wa[w]]  = wd[w];
          m_busy[wa[w]] = 1'b0;
        end
      end
      if (re && rsa != 0) m_busy[rsa] = 1'b1;
      m_conf = nconf;
      if (c_we[0] && c_wa[0] != 0) c_mem[c_wa[0]] = c_wd[0];
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every DUT output against the queued expectation,
  // sampled mid-cycle while the inputs are stable.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("a_data[%0d]", i), 64'(a_do[i]), 64'(e.a_data[i]));
          chk($sformatf("a_busy[%0d]", i), 64'(a_busy[i]), 64'(e.a_busy[i]));
          chk($sformatf("b_data[%0d]", i), 64'(b_do[i]), 64'(e.b_data[i]));
          chk($sformatf("b_busy[%0d]", i), 64'(b_busy[i]), 64'(e.b_busy[i]));
        end
        chk("a_conflict", 64'(a_wc), 64'(e.conflict));
        chk("b_conflict", 64'(b_wc), 64'(e.conflict));
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("c_data[%0d]", i), c_do[i], e.c_data[i]);
          chk($sformatf("c_busy[%0d]", i), 64'(c_busy[i]), 64'd0);
        end
        chk("c_conflict", 64'(c_wc), 64'd0);
      end
    end
  end

  initial begin : driver
    reset = 1'b1; we = '0; wa = '0; wd = '0; ra = '0; re = 1'b0; rsa = '0;
    c_we = '0; c_wa = '0; c_wd = '0; c_ra = '0;
    for (int r = 0; r < 32; r++) begin m_mem[r] = '0; m_busy[r] = 1'b0; end
    for (int r = 0; r < 16; r++) c_mem[r] = '0;
    m_conf = 1'b0;
    @(posedge clk);
    #1;
    step(); step();
    reset = 1'b0;

    // x5 written and read in the same cycle, then a collision on x20
    we = 2'b01; wa[0] = 5'd5; wd[0] = 32'hABCDEFFF; ra[0] = 5'd5; ra[1] = 5'd5; step();
    we = 2'b11; wa[0] = 5'd20; wa[1] = 5'd20; wd[0] = 32'd1; wd[1] = 32'd2; step();
    // reset raised mid-cycle with a write pending on x5
    reset = 1'b1; we = 2'b01; wa[0] = 5'd5; wd[0] = 32'h12345678; step();
    reset = 1'b0; we = 2'b00; step();

    // hardwired zero: colliding writes and a reservation on x0
    we = 2'b11; wa[0] = 5'd0; wa[1] = 5'd0; wd[0] = 32'hFFFABCDE; wd[1] = 32'h13572468;
    re = 1'b1; rsa = 5'd0; ra[0] = 5'd0; ra[1] = 5'd0; step();
    we = 2'b00; re = 1'b0; step(); step();

    // bypass of x9, plus the wide instance writing its top register
    we = 2'b01; wa[0] = 5'd9; wd[0] = 32'hABEFFFCD; ra[0] = 5'd9; ra[1] = 5'd9;
    c_we = 1'b1; c_wa[0] = 4'd15; c_wd[0] = 64'hDEADBEEFCAFEF00D;
    c_ra[0] = 4'd15; c_ra[1] = 4'd15; c_ra[2] = 4'd15; step();
    we = 2'b00; c_we = 1'b0; step();
    c_ra[1] = 4'd14; c_ra[2] = 4'd0; step();

    // collision on x31
    we = 2'b11; wa[0] = 5'd31; wa[1] = 5'd31; wd[0] = 32'h11111111; wd[1] = 32'h22222222;
    ra[0] = 5'd31; ra[1] = 5'd9; step();
    we = 2'b00; step(); step();

    // scoreboard on x7
    ra[0] = 5'd7; ra[1] = 5'd7; re = 1'b1; rsa = 5'd7; step();
    re = 1'b0; step();
    re = 1'b1; we = 2'b01; wa[0] = 5'd7; wd[0] = 32'h77; step();
    re = 1'b0; we = 2'b00; step();
    we = 2'b01; wa[0] = 5'd7; wd[0] = 32'h78; step();
    we = 2'b00; step();

    // randomized traffic over a narrow address window to provoke hits
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      we    = 2'($urandom);
      re    = 1'($urandom);
      rsa   = 5'($urandom_range(0, 7));
      for (int w = 0; w < 2; w++) begin
        wa[w] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
        wd[w] = $urandom;
        ra[w] = 5'($urandom_range(0, 7));
      end
      c_we    = 1'($urandom);
      c_wa[0] = 4'($urandom);
      c_wd[0] = {$urandom, $urandom};
      for (int i = 0; i < 3; i++) c_ra[i] = 4'($urandom);
      step();
    end
    reset = 1'b0; we = '0; re = 1'b0; c_we = '0;

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
